// File: rtl/loop_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : loop_ctrl_pkg
//  Purpose  : Shared state encoding and default index widths for the
//             two-level loop controller.
//  Revision : 1.0 - initial release
// ============================================================================
package loop_ctrl_pkg;

    // Default index widths (inner x outer loop nest)
    localparam int c_INNER_W_DEF = 6;
    localparam int c_OUTER_W_DEF = 5;

    // Sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        REQ  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage : loop_ctrl_pkg
`default_nettype wire

// File: rtl/loop_counter.sv
`default_nettype none
// ============================================================================
//  Module   : loop_counter
//  Purpose  : Up-counter that wraps to zero after reaching a programmable
//             limit; flags when the current value equals the limit.
//  Revision : 1.0 - initial release
// ============================================================================
module loop_counter #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         rst,        // asynchronous, active-low
    input  logic         i_clr,
    input  logic         i_en,
    input  logic [W-1:0] i_limit,
    output logic [W-1:0] o_count,
    output logic         o_at_limit
);

    logic [W-1:0] r_count;
    logic         w_at_limit;

    assign w_at_limit = (r_count == i_limit);

    // Clear has priority; otherwise step and wrap to zero after the limit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= w_at_limit ? '0 : r_count + 1'b1;
        end
    end

    assign o_count    = r_count;
    assign o_at_limit = w_at_limit;

endmodule : loop_counter
`default_nettype wire

// File: rtl/loop_controller.sv
`default_nettype none
// ============================================================================
//  Module   : loop_controller
//  Purpose  : Sequences an outer x inner iteration nest, issuing one datapath
//             request per index pair (held until acknowledged), then pulses
//             done for one cycle.
//  Config   : LOOP_PAUSE_EN - adds a pause input that freezes sequencing
//             while the controller is issuing requests.
//  Revision : 1.0 - initial release
// ============================================================================
module loop_controller
    import loop_ctrl_pkg::*;
#(
    parameter int INNER_W = c_INNER_W_DEF,
    parameter int OUTER_W = c_OUTER_W_DEF
) (
    input  logic               clk,
    input  logic               rst,          // asynchronous, active-low
    input  logic               start,
    input  logic [INNER_W-1:0] inner_last,
    input  logic [OUTER_W-1:0] outer_last,
    input  logic               dp_ack,
`ifdef LOOP_PAUSE_EN
    input  logic               pause,
`endif
    output logic               busy,
    output logic               done,
    output logic               dp_req,
    output logic [INNER_W-1:0] inner_idx,
    output logic [OUTER_W-1:0] outer_idx,
    output logic               inner_first,
    output logic               inner_last_o
);

    state_t             r_state;
    logic [INNER_W-1:0] r_inner_last_q;
    logic [OUTER_W-1:0] r_outer_last_q;
    logic               r_busy;
    logic               r_done;
    logic               r_req;

    logic               w_pause;
    logic               w_step;
    logic               w_inner_at;
    logic               w_outer_at;
    logic               w_final;
    logic               w_clr;
    logic               w_inner_en;
    logic               w_outer_en;
    logic               w_dp_req;

`ifdef LOOP_PAUSE_EN
    assign w_pause = pause;
`else
    assign w_pause = 1'b0;
`endif

    // r_req is high exactly while in REQ; an accepted request is one step
    assign w_step  = r_req & dp_ack & ~w_pause;
    assign w_final = w_inner_at & w_outer_at;
    assign w_clr   = (r_state == LOAD);

    // Inner advances on every step except the final one, so indices hold
    // their last values in DONE; outer advances only when inner wraps.
    assign w_inner_en = w_step & ~w_final;
    assign w_outer_en = w_step & w_inner_at & ~w_outer_at;

    loop_counter #(.W(INNER_W)) u_inner (
        .clk        (clk),
        .rst        (rst),
        .i_clr      (w_clr),
        .i_en       (w_inner_en),
        .i_limit    (r_inner_last_q),
        .o_count    (inner_idx),
        .o_at_limit (w_inner_at)
    );

    loop_counter #(.W(OUTER_W)) u_outer (
        .clk        (clk),
        .rst        (rst),
        .i_clr      (w_clr),
        .i_en       (w_outer_en),
        .i_limit    (r_outer_last_q),
        .o_count    (outer_idx),
        .o_at_limit (w_outer_at)
    );

    // Sequencer: IDLE -> LOAD -> REQ -> DONE -> IDLE, with registered status
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= IDLE;
            r_inner_last_q <= '0;
            r_outer_last_q <= '0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_req          <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_inner_last_q <= inner_last;
                        r_outer_last_q <= outer_last;
                        r_busy         <= 1'b1;
                        r_state        <= LOAD;
                    end
                end
                LOAD: begin
                    r_req   <= 1'b1;
                    r_state <= REQ;
                end
                REQ: begin
                    if (w_step && w_final) begin
                        r_req   <= 1'b0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // A paused request is withdrawn so the datapath cannot accept it
    assign w_dp_req     = r_req & ~w_pause;
    assign dp_req       = w_dp_req;
    assign busy         = r_busy;
    assign done         = r_done;
    assign inner_first  = w_dp_req & (inner_idx == '0);
    assign inner_last_o = w_dp_req & w_inner_at;

endmodule : loop_controller
`default_nettype wire

// File: tb/tb_loop_controller.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_loop_controller
//  Purpose  : Self-checking bench for loop_controller; expected indices are
//             derived from the count of accepted requests.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_loop_controller;

    localparam int IW = 6;
    localparam int OW = 5;

    logic          clk        = 1'b0;
    logic          rst        = 1'b0;
    logic          start      = 1'b0;
    logic          dp_ack     = 1'b0;
    logic [IW-1:0] inner_last = '0;
    logic [OW-1:0] outer_last = '0;
`ifdef LOOP_PAUSE_EN
    logic          pause      = 1'b0;
`endif
    logic          busy, done, dp_req, inner_first, inner_last_o;
    logic [IW-1:0] inner_idx;
    logic [OW-1:0] outer_idx;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    loop_controller #(.INNER_W(IW), .OUTER_W(OW)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .inner_last   (inner_last),
        .outer_last   (outer_last),
        .dp_ack       (dp_ack),
`ifdef LOOP_PAUSE_EN
        .pause        (pause),
`endif
        .busy         (busy),
        .done         (done),
        .dp_req       (dp_req),
        .inner_idx    (inner_idx),
        .outer_idx    (outer_idx),
        .inner_first  (inner_first),
        .inner_last_o (inner_last_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_busy"},  busy,         0);
        chk({tag, "_done"},  done,         0);
        chk({tag, "_req"},   dp_req,       0);
        chk({tag, "_first"}, inner_first,  0);
        chk({tag, "_lasto"}, inner_last_o, 0);
    endtask

    // One run: il/ol are the limits, pct the ack probability, noise pulses
    // start and scrambles limit inputs mid-run, abort_k resets on that
    // accept count, pause_k pauses five cycles on that accept count.
    task automatic run(input int il, input int ol, input int pct, input bit noise,
                       input int abort_k, input int pause_k);
        int k, total, cyc, pleft, ei;
        bit ack, pz, pause_used;
        k = 0; cyc = 0; pleft = 0; pause_used = 0;
        total = (il + 1) * (ol + 1);

        @(negedge clk);
        inner_last = IW'(il);
        outer_last = OW'(ol);
        start      = 1'b1;
        dp_ack     = 1'b1;
        #1;
        chk("idle_busy", busy, 0);
        chk("idle_req",  dp_req, 0);

        @(negedge clk);
        start = 1'b0;
        if (noise) begin
            inner_last = IW'($urandom_range(0, 63));
            outer_last = OW'($urandom_range(0, 31));
        end
        #1;
        chk("load_busy", busy, 1);
        chk("load_req",  dp_req, 0);
        chk("load_done", done, 0);

        while (k < total) begin
            if (cyc > 2000) begin
                n_tests++;
                n_fail++;
                $error("FAIL timeout: observed %0d accepts expected %0d", k, total);
                return;
            end
            @(negedge clk);
            ack = ($urandom_range(0, 99) < pct);
            pz  = 1'b0;
`ifdef LOOP_PAUSE_EN
            if (k == pause_k && !pause_used) begin
                pleft      = 5;
                pause_used = 1'b1;
            end
            pz = (pleft > 0);
            if (pleft > 0) pleft--;
            pause = pz;
`endif
            dp_ack = ack;
            if (noise) begin
                start      = 1'($urandom_range(0, 1));
                inner_last = IW'($urandom_range(0, 63));
                outer_last = OW'($urandom_range(0, 31));
            end
            #1;
            ei = k % (il + 1);
            chk("req_valid", dp_req, !pz);
            chk("req_busy",  busy, 1);
            chk("req_done",  done, 0);
            chk("req_inner", inner_idx, ei);
            chk("req_outer", outer_idx, k / (il + 1));
            chk("req_first", inner_first, (!pz && ei == 0));
            chk("req_lasto", inner_last_o, (!pz && ei == il));
            if (k == abort_k) begin
                rst = 1'b0;
                #1;
                chk_quiet("rst");
                chk("rst_inner", inner_idx, 0);
                chk("rst_outer", outer_idx, 0);
                @(negedge clk);
                rst    = 1'b1;
                dp_ack = 1'b0;
                start  = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    #1;
                    chk_quiet("post_rst");
                end
                return;
            end
            if (!pz && ack) k++;
            cyc++;
        end

        @(negedge clk);
        start  = noise;
        dp_ack = 1'b1;
        #1;
        chk("done_pulse", done, 1);
        chk("done_busy",  busy, 0);
        chk("done_req",   dp_req, 0);
        chk("done_inner", inner_idx, il);
        chk("done_outer", outer_idx, ol);
        @(negedge clk);
        start = 1'b0;
        #1;
        chk_quiet("after_done");
        @(negedge clk);
        dp_ack = 1'b0;
        #1;
        chk_quiet("idle_again");
    endtask

    initial begin
        rst = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk_quiet("reset");
        chk("reset_inner", inner_idx, 0);
        chk("reset_outer", outer_idx, 0);
        @(negedge clk);
        rst = 1'b1;

        run(3, 2, 100, 1'b0, 7, -1);     // reset mid-REQ at inner=3, outer=1
        run(0, 0, 100, 1'b0, -1, -1);    // single-iteration run
        run(3, 2, 100, 1'b0, -1, -1);    // full-rate 4x3 nest
        run(3, 2, 30, 1'b0, -1, -1);     // sparse acks
        run(3, 2, 60, 1'b1, -1, -1);     // start/limit noise during the run
`ifdef LOOP_PAUSE_EN
        run(3, 2, 100, 1'b0, -1, 6);     // pause at inner=2, outer=1
`endif
        repeat (4) begin
            run(int'($urandom_range(0, 5)), int'($urandom_range(0, 3)),
                int'($urandom_range(40, 100)), 1'($urandom_range(0, 1)), -1, -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_loop_controller
`default_nettype wire
